// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared constants, state encoding and segment decode for the seven-segment scan controller
package seven_seg_pkg;

  localparam int DIGIT_CNT = 3;
  localparam int BCD_W     = 4 * DIGIT_CNT;

  // Segment patterns, bit0=a ... bit6=g, active-high
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t SHIFT  = 2'd1;
  localparam state_t COMMIT = 2'd2;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seven_seg_bin2bcd.sv
// rtl/seven_seg_bin2bcd.sv - sequential double-dabble binary to BCD, one input bit per cycle
module seven_seg_bin2bcd
  import seven_seg_pkg::*;
#(
  parameter int DATA_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              done,
  output logic [BCD_W-1:0]  bcd
);

  localparam int SR_W  = BCD_W + DATA_W;
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [SR_W-1:0]  sreg;
  logic [SR_W-1:0]  sreg_adj;
  logic [CNT_W-1:0] cnt;
  logic             active;

  always_comb begin
    sreg_adj = sreg;
    for (int i = 0; i < DIGIT_CNT; i++) begin
      if (sreg[DATA_W + 4*i +: 4] >= 4'd5)
        sreg_adj[DATA_W + 4*i +: 4] = sreg[DATA_W + 4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg   <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      sreg   <= {{BCD_W{1'b0}}, data_in};
      cnt    <= CNT_W'(DATA_W);
      active <= 1'b1;
    end else if (active) begin
      sreg <= {sreg_adj[SR_W-2:0], 1'b0};
      cnt  <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1))
        active <= 1'b0;
    end
  end

  // Asserted during the cycle whose closing edge performs the final shift
  assign done = active && (cnt == CNT_W'(1));
  assign bcd  = sreg[SR_W-1 -: BCD_W];

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - 3-digit multiplexed seven-segment controller with handshake input and BCD conversion
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int DATA_W     = 7,
  parameter int NUM_DIGITS = 3,
  parameter int SCAN_DIV   = 1000,
  parameter int BLANK_LZ   = 1
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [DATA_W-1:0]     DataIn,
  input  logic                  DataValid,
  output logic                  DataReady,
  output logic                  Busy,
  output logic [6:0]            SegOut,
  output logic [NUM_DIGITS-1:0] DigitEn
);

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_t           state;
  logic [BCD_W-1:0] disp;
  logic [BCD_W-1:0] conv_bcd;
  logic             conv_done;
  logic             accept;
  logic [PRE_W-1:0] presc;
  logic [1:0]       idx;
  logic [3:0]       cur_nib;
  logic             cur_blank;

  assign DataReady = (state == IDLE);
  assign Busy      = (state != IDLE);
  assign accept    = DataValid && DataReady;

  seven_seg_bin2bcd #(.DATA_W(DATA_W)) u_bin2bcd (
    .clk     (Clk),
    .rst_n   (Rst_n),
    .start   (accept),
    .data_in (DataIn),
    .done    (conv_done),
    .bcd     (conv_bcd)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
      disp  <= '0;
    end else begin
      case (state)
        IDLE:    if (accept) state <= SHIFT;
        SHIFT:   if (conv_done) state <= COMMIT;
        COMMIT: begin
          disp  <= conv_bcd;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Scan timing runs freely, unaffected by conversions in flight
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PRE_W'(SCAN_DIV - 1)) begin
      presc <= '0;
      idx   <= (idx == 2'(NUM_DIGITS - 1)) ? 2'd0 : idx + 2'd1;
    end else begin
      presc <= presc + PRE_W'(1);
    end
  end

  always_comb begin
    cur_nib   = disp[3:0];
    cur_blank = 1'b0;
    case (idx)
      2'd0: begin
        cur_nib   = disp[11:8];
        cur_blank = (BLANK_LZ != 0) && (disp[11:8] == 4'd0);
      end
      2'd1: begin
        cur_nib   = disp[7:4];
        cur_blank = (BLANK_LZ != 0) && (disp[11:4] == 8'd0);
      end
      default: ;
    endcase
  end

  // Segment and enable registers share an edge so the bus never ghosts
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      SegOut  <= SEG_BLANK;
      DigitEn <= '0;
    end else begin
      SegOut  <= cur_blank ? SEG_BLANK : seg_decode(cur_nib);
      DigitEn <= NUM_DIGITS'(1) << idx;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb/tb_seven_seg_scan_ctrl.sv - directed self-checking bench for seven_seg_scan_ctrl
module tb_seven_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] din_a = '0, din_b = '0;
  logic       valid_a = 1'b0, valid_b = 1'b0;
  logic       ready_a, busy_a, ready_b, busy_b;
  logic [6:0] seg_a, seg_b;
  logic [2:0] en_a, en_b;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(.DATA_W(7), .NUM_DIGITS(3), .SCAN_DIV(4), .BLANK_LZ(1)) dut_a (
    .Clk(clk), .Rst_n(rst_n), .DataIn(din_a), .DataValid(valid_a),
    .DataReady(ready_a), .Busy(busy_a), .SegOut(seg_a), .DigitEn(en_a)
  );

  seven_seg_scan_ctrl #(.DATA_W(7), .NUM_DIGITS(3), .SCAN_DIV(1), .BLANK_LZ(0)) dut_b (
    .Clk(clk), .Rst_n(rst_n), .DataIn(din_b), .DataValid(valid_b),
    .DataReady(ready_b), .Busy(busy_b), .SegOut(seg_b), .DigitEn(en_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_slots_a(input logic [6:0] h, input logic [6:0] t, input logic [6:0] o, input string tag);
    logic [6:0] exp_seg [3];
    logic [2:0] exp_en;
    int waited;
    exp_seg[0] = h;
    exp_seg[1] = t;
    exp_seg[2] = o;
    waited = 0;
    while (en_a === 3'b001 && waited < 20) begin step(); waited++; end
    while (en_a !== 3'b001 && waited < 40) begin step(); waited++; end
    if (en_a !== 3'b001) begin
      total_cnt++;
      $display("FAIL %s scan_sync: DigitEn=%b, required 001 within 40 cycles", tag, en_a);
      return;
    end
    for (int k = 0; k < 12; k++) begin
      if (k > 0) step();
      exp_en = 3'b001 << (k / 4);
      total_cnt++;
      if (en_a !== exp_en || seg_a !== exp_seg[k/4])
        $display("FAIL %s slot%0d: DigitEn=%b SegOut=%h, required DigitEn=%b SegOut=%h",
                 tag, k, en_a, seg_a, exp_en, exp_seg[k/4]);
      else
        pass_cnt++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    total_cnt++;
    if ({seg_a, en_a, ready_a, busy_a} !== {7'h00, 3'b000, 1'b1, 1'b0})
      $display("FAIL reset_a: seg=%h en=%b ready=%b busy=%b, required 00 000 1 0", seg_a, en_a, ready_a, busy_a);
    else pass_cnt++;
    total_cnt++;
    if ({seg_b, en_b, ready_b, busy_b} !== {7'h00, 3'b000, 1'b1, 1'b0})
      $display("FAIL reset_b: seg=%h en=%b ready=%b busy=%b, required 00 000 1 0", seg_b, en_b, ready_b, busy_b);
    else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_scan_idle();
    check_slots_a(7'h00, 7'h00, 7'h3F, "idle_zero");
  endtask

  task automatic test_convert_127();
    int bad;
    valid_a = 1'b1;
    din_a   = 7'd127;
    step();
    valid_a = 1'b0;
    total_cnt++;
    if (ready_a !== 1'b0 || busy_a !== 1'b1)
      $display("FAIL c127_accept: ready=%b busy=%b, required 0 1", ready_a, busy_a);
    else pass_cnt++;
    bad = 0;
    for (int i = 1; i <= 7; i++) begin
      step();
      if (ready_a !== 1'b0 || busy_a !== 1'b1) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL c127_busy_window: %0d bad cycles, required 0", bad);
    else pass_cnt++;
    step();
    total_cnt++;
    if (dut_a.disp !== 12'h127 || ready_a !== 1'b1 || busy_a !== 1'b0)
      $display("FAIL c127_commit: disp=%h ready=%b busy=%b, required 127 1 0", dut_a.disp, ready_a, busy_a);
    else pass_cnt++;
    check_slots_a(7'h06, 7'h5B, 7'h07, "c127");
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp_seg;
    valid_a = 1'b1;
    din_a   = 7'd5;
    step();
    valid_a = 1'b0;
    repeat (8) step();
    total_cnt++;
    if (dut_a.disp !== 12'h005 || ready_a !== 1'b1)
      $display("FAIL b2b_first_commit: disp=%h ready=%b, required 005 1", dut_a.disp, ready_a);
    else pass_cnt++;
    valid_a = 1'b1;
    din_a   = 7'd100;
    step();
    valid_a = 1'b0;
    total_cnt++;
    if (ready_a !== 1'b0 || busy_a !== 1'b1)
      $display("FAIL b2b_second_accept: ready=%b busy=%b, required 0 1", ready_a, busy_a);
    else pass_cnt++;
    exp_seg = (en_a == 3'b100) ? 7'h6D : 7'h00;
    total_cnt++;
    if (seg_a !== exp_seg)
      $display("FAIL b2b_first_visible: SegOut=%h on en=%b, required %h", seg_a, en_a, exp_seg);
    else pass_cnt++;
    repeat (8) step();
    total_cnt++;
    if (dut_a.disp !== 12'h100)
      $display("FAIL b2b_second_commit: disp=%h, required 100", dut_a.disp);
    else pass_cnt++;
    check_slots_a(7'h06, 7'h3F, 7'h3F, "b2b_100");
  endtask

  task automatic test_ignore_busy();
    valid_a = 1'b1;
    din_a   = 7'd42;
    step();
    valid_a = 1'b0;
    repeat (2) step();
    valid_a = 1'b1;
    din_a   = 7'd99;
    #1;
    total_cnt++;
    if (ready_a !== 1'b0)
      $display("FAIL ignore_ready_low: ready=%b, required 0", ready_a);
    else pass_cnt++;
    step();
    valid_a = 1'b0;
    repeat (5) step();
    total_cnt++;
    if (dut_a.disp !== 12'h042 || ready_a !== 1'b1)
      $display("FAIL ignore_commit: disp=%h ready=%b, required 042 1", dut_a.disp, ready_a);
    else pass_cnt++;
    step();
    total_cnt++;
    if (busy_a !== 1'b0)
      $display("FAIL ignore_no_requeue: busy=%b, required 0", busy_a);
    else pass_cnt++;
    check_slots_a(7'h00, 7'h66, 7'h5B, "ignore_42");
  endtask

  task automatic test_reset_mid();
    logic seen88;
    valid_a = 1'b1;
    din_a   = 7'd88;
    step();
    valid_a = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({seg_a, en_a, ready_a, busy_a} !== {7'h00, 3'b000, 1'b1, 1'b0} || dut_a.disp !== 12'h000)
      $display("FAIL rst_mid_outputs: seg=%h en=%b ready=%b busy=%b disp=%h, required 00 000 1 0 000",
               seg_a, en_a, ready_a, busy_a, dut_a.disp);
    else pass_cnt++;
    step();
    step();
    rst_n = 1'b1;
    seen88 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (dut_a.disp === 12'h088 || seg_a === 7'h7F) seen88 = 1'b1;
    end
    total_cnt++;
    if (seen88 !== 1'b0)
      $display("FAIL rst_mid_no_88: seen=%b, required 0", seen88);
    else pass_cnt++;
    check_slots_a(7'h00, 7'h00, 7'h3F, "rst_mid");
  endtask

  task automatic test_noblank_fast();
    logic [6:0] exp_seg [3];
    logic [2:0] exp_en;
    int waited;
    exp_seg[0] = 7'h3F;
    exp_seg[1] = 7'h3F;
    exp_seg[2] = 7'h07;
    valid_b = 1'b1;
    din_b   = 7'd7;
    step();
    valid_b = 1'b0;
    repeat (8) step();
    total_cnt++;
    if (dut_b.disp !== 12'h007 || ready_b !== 1'b1)
      $display("FAIL fast_commit: disp=%h ready=%b, required 007 1", dut_b.disp, ready_b);
    else pass_cnt++;
    step();
    waited = 0;
    while (en_b !== 3'b001 && waited < 6) begin step(); waited++; end
    if (en_b !== 3'b001) begin
      total_cnt++;
      $display("FAIL fast_sync: DigitEn=%b, required 001 within 6 cycles", en_b);
      return;
    end
    for (int k = 0; k < 6; k++) begin
      if (k > 0) step();
      exp_en = 3'b001 << (k % 3);
      total_cnt++;
      if (en_b !== exp_en || seg_b !== exp_seg[k%3])
        $display("FAIL fast_slot%0d: DigitEn=%b SegOut=%h, required DigitEn=%b SegOut=%h",
                 k, en_b, seg_b, exp_en, exp_seg[k%3]);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_scan_idle();
    test_convert_127();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    test_noblank_fast();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
Controller for a 3-digit multiplexed seven-segment display.
- Accepts a 7-bit binary value over a valid/ready handshake.
- Converts it to BCD sequentially (double-dabble, one bit per cycle) and commits the digits atomically to a display register.
- Time-multiplexes one shared segment bus across the digits with a prescaled scan counter.
- Sits between the value producer and the physical segment/digit-enable pins.

Parameters:
- DATA_W, 7: binary input width. Fixed 7; max value 127.
- NUM_DIGITS, 3: digits scanned (hundreds, tens, ones).
- SCAN_DIV, 1000: clock cycles per digit slot. Must be >= 1.
- BLANK_LZ, 1: 1 = blank leading zeros; 0 = show all digits.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- DataIn  in  7  unsigned binary value to display.
- DataValid  in  1  producer asserts while DataIn is valid.
- DataReady  out  1  high only in IDLE; transfer occurs when DataValid && DataReady at a rising edge.
- Busy  out  1  high in SHIFT or COMMIT.
- SegOut  out  7  segment pattern, active-high; bit0=a ... bit6=g; registered.
- DigitEn  out  3  one-hot digit enable, active-high, registered; [0]=hundreds, [1]=tens, [2]=ones.

Behaviour:
Reset (async assert, sync-safe deassert inside):
- FSM=IDLE; display BCD register=000.
- Scan index=0; prescaler=0.
- SegOut=7'h00; DigitEn=3'b000; Busy=0; DataReady=1.

Conversion FSM:
- IDLE: DataReady=1.
  - On handshake at edge T: load shift reg {12'b0, DataIn}, bit counter=7, go to SHIFT.
- SHIFT: each cycle, for every BCD nibble >= 5 add 3, then shift the whole register left by 1; decrement the counter.
  - Edges T+1..T+7; after the 7th shift go to COMMIT.
- COMMIT (edge T+8): copy the 3 BCD nibbles to the display register in one cycle, go to IDLE.
  - DataReady high again from T+8.
- Latency: handshake to display-register update = 8 cycles. SegOut reflects the new value 1 cycle later, on whatever digit is currently scanned.
- DataValid while not IDLE: ignored, no queueing; the producer holds the value.
- DataIn changes during SHIFT: no effect.
- Back-to-back: a handshake in the same cycle that COMMIT returns to IDLE is accepted; throughput is one value per 9 cycles.
- Reset mid-conversion: conversion aborts; the display register clears to 0, not the old value.

Scan:
- Prescaler counts 0..SCAN_DIV-1 continuously, independent of the FSM.
- On wrap, index advances 0->1->2->0.
- SCAN_DIV=1: index advances every cycle.
- Each cycle, registers update to DigitEn=onehot(index) and SegOut=decode(digit[index]), with 1-cycle latency from index/display change. DigitEn and SegOut always change on the same edge, so there is no glitch/ghosting.

Decode (hex):
- 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- Nibbles > 9 (unreachable) decode to 00.

Blanking (BLANK_LZ=1):
- Hundreds blank (SegOut=00) if 0.
- Tens blank if hundreds and tens are both 0.
- Ones never blank; value 0 shows as a lone "0".
- DigitEn still cycles through blanked digits, so the duty cycle is unchanged.

Decomposition:
- Package seven_seg_pkg:
  - segment-code constants SEG_0..SEG_9 and SEG_BLANK;
  - FSM state typedef {IDLE, SHIFT, COMMIT};
  - NUM_DIGITS/BCD width localparams.
- Sub-module seven_seg_bin2bcd: sequential double-dabble.
  - Interface: start, DataIn, done pulse, 12-bit bcd out.
  - Top keeps handshake, display register, scan, decode and blanking.

Test Plan:
- Reset released, no input, SCAN_DIV=4:
  - DigitEn cycles 001,010,100 every 4 cycles.
  - SegOut = 00, 00, 3F for hundreds/tens/ones.
- DataIn=127 handshake at edge T:
  - DataReady low T..T+7, Busy high; display register = 1,2,7 at T+8.
  - Slots show 06, 5B, 07.
- DataIn=5 then, once ready, DataIn=100 back-to-back:
  - First shows 00,00,6D.
  - Second accepted at the COMMIT-exit edge and shows 06,3F,3F; the tens zero is not blanked.
- DataValid pulsed with DataIn=99 while Busy (mid-SHIFT), then dropped:
  - Ignored; the display keeps the in-flight value.
  - DataReady never high in that cycle.
- Rst_n asserted at T+4 of a DataIn=88 conversion:
  - Outputs immediately reset values; after release the display shows lone "0".
  - No 88 ever appears.
- BLANK_LZ=0, SCAN_DIV=1, DataIn=7:
  - DigitEn advances each cycle; SegOut = 3F,3F,07 in sequence, aligned with DigitEn on the same edges.
